rf_wr_arbiter: RTL

//  Owns the single write port of the 32x32 general register file. After reset it runs an

---
 rtl/rf_wr_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rf_wr_arbiter.sv
// Owns the RF write port: zero-inits x1..x(REG_NUM-1) after reset, then arbitrates WB/load/debug writes.
// Latency: an accepted request shows on rf_wr_* one cycle later; init writes one register per cycle.
// Backpressure: combinational ready to at most one requester per cycle; no buffering, losers hold.
module rf_wr_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int REG_NUM    = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_req,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_ready,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic              dbg_valid,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_data,
   output logic              dbg_ready,
   output logic              rf_wr_en,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic              init_done
);

   localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_W-1:0] LAST_REG   = ADDR_W'(REG_NUM - 1);
   localparam logic [CNT_W-1:0]  STARVE_SAT = CNT_W'(STARVE_MAX);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0]  ld_cnt, ld_cnt_nxt;
   logic [CNT_W-1:0]  dbg_cnt, dbg_cnt_nxt;
   logic              ld_starved, dbg_starved;
   logic              grant_wb, grant_ld, grant_dbg;
   logic              wr_en_nxt;
   logic [ADDR_W-1:0] wr_addr_nxt;
   logic [DATA_W-1:0] wr_data_nxt;

   // A waiting requester whose loss count has saturated overrides the fixed priority.
   always_comb begin
      ld_starved  = ld_valid && (ld_cnt == STARVE_SAT);
      dbg_starved = dbg_valid && (dbg_cnt == STARVE_SAT);
   end

   // Next state, grant selection, starvation counting and staging of the registered write.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      grant_wb    = 1'b0;
      grant_ld    = 1'b0;
      grant_dbg   = 1'b0;
      wr_en_nxt   = 1'b0;
      wr_addr_nxt = '0;
      wr_data_nxt = '0;
      ld_cnt_nxt  = '0;
      dbg_cnt_nxt = '0;
      case (state)
         S_INIT: begin
            if (clear_req) begin
               cnt_nxt = ADDR_W'(1);
            end else begin
               wr_en_nxt   = 1'b1;
               wr_addr_nxt = cnt;
               cnt_nxt     = cnt + 1'b1;
               if (cnt == LAST_REG) state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (clear_req) begin
               state_nxt = S_INIT;
               cnt_nxt   = ADDR_W'(1);
            end else if (dbg_starved) begin
               grant_dbg = 1'b1;
            end else if (ld_starved) begin
               grant_ld = 1'b1;
            end else if (wb_valid) begin
               grant_wb = 1'b1;
            end else if (ld_valid) begin
               grant_ld = 1'b1;
            end else if (dbg_valid) begin
               grant_dbg = 1'b1;
            end
            // x0 is hardwired zero: such requests complete the handshake but never write.
            if (grant_wb && wb_addr != '0) begin
               wr_en_nxt   = 1'b1;
               wr_addr_nxt = wb_addr;
               wr_data_nxt = wb_data;
            end else if (grant_ld && ld_addr != '0) begin
               wr_en_nxt   = 1'b1;
               wr_addr_nxt = ld_addr;
               wr_data_nxt = ld_data;
            end else if (grant_dbg && dbg_addr != '0) begin
               wr_en_nxt   = 1'b1;
               wr_addr_nxt = dbg_addr;
               wr_data_nxt = dbg_data;
            end
            ld_cnt_nxt  = (ld_valid && !grant_ld) ?
                          ((ld_cnt == STARVE_SAT) ? ld_cnt : ld_cnt + 1'b1) : '0;
            dbg_cnt_nxt = (dbg_valid && !grant_dbg) ?
                          ((dbg_cnt == STARVE_SAT) ? dbg_cnt : dbg_cnt + 1'b1) : '0;
         end
         default: state_nxt = S_INIT;
      endcase
   end

   assign wb_ready  = wb_valid  & grant_wb  & (state == S_RUN);
   assign ld_ready  = ld_valid  & grant_ld  & (state == S_RUN);
   assign dbg_ready = dbg_valid & grant_dbg & (state == S_RUN);
   assign init_done = (state == S_RUN);

   // State, counters and the registered RF write port; reset cancels any staged write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_INIT;
         cnt        <= ADDR_W'(1);
         ld_cnt     <= '0;
         dbg_cnt    <= '0;
         rf_wr_en   <= 1'b0;
         rf_wr_addr <= '0;
         rf_wr_data <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         ld_cnt     <= ld_cnt_nxt;
         dbg_cnt    <= dbg_cnt_nxt;
         rf_wr_en   <= wr_en_nxt;
         rf_wr_addr <= wr_addr_nxt;
         rf_wr_data <= wr_data_nxt;
      end
   end

endmodule
